// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU bus arbiter and the OAM DMA engine.
package bus_pkg;

  typedef enum logic [1:0] {
    DMA_IDLE  = 2'd0,
    DMA_DELAY = 2'd1,
    DMA_XFER  = 2'd2
  } dma_state_t;

  localparam logic [7:0]  HP_PAGE          = 8'hFF;
  localparam logic [15:0] OAM_BASE         = 16'hFE00;
  localparam logic [15:0] DEF_DMA_REG_ADDR = 16'hFF46;

  localparam int unsigned IDX_W = 8;
  localparam int unsigned DLY_W = 2;

endpackage

// File: rtl/oam_dma_engine.sv
// OAM DMA engine: start delay, page copy sequencing and the registered OAM write port.
// Optional macro OAMDMA_ECHO_MIRROR_EN folds source pages E0-FF down onto C0-DF.
module oam_dma_engine
  import bus_pkg::*;
#(
  parameter int unsigned DMA_LEN     = 160,
  parameter int unsigned START_DELAY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_c,
  input  logic [7:0]       start_src,
  input  logic [7:0]       bus_rdata,
  output logic             xfer_c,
  output logic [15:0]      dma_addr_c,
  output logic [7:0]       src,
  output logic             oam_we,
  output logic [IDX_W-1:0] oam_addr,
  output logic [7:0]       oam_wdata,
  output logic             dma_active
);

  dma_state_t       state_q, state_d;
  logic [7:0]       src_q, src_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic             pend_q, pend_d;
  logic [7:0]       data_q, data_d;
  logic [IDX_W-1:0] oam_addr_q, oam_addr_d;
  logic [7:0]       src_eff;

`ifdef OAMDMA_ECHO_MIRROR_EN
  assign src_eff = (src_q >= 8'hE0) ? (src_q & 8'hDF) : src_q;
`else
  assign src_eff = src_q;
`endif

  // Next-state: delay countdown, one DMA read per XFER cycle, FF46 write (re)starts.
  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    idx_d      = idx_q;
    dly_d      = dly_q;
    pend_d     = 1'b0;
    data_d     = 8'h00;
    oam_addr_d = '0;
    case (state_q)
      DMA_IDLE: begin
        state_d = DMA_IDLE;
      end
      DMA_DELAY: begin
        dly_d = dly_q + DLY_W'(1);
        if (dly_q == DLY_W'(START_DELAY - 1)) state_d = DMA_XFER;
      end
      DMA_XFER: begin
        pend_d     = 1'b1;
        data_d     = bus_rdata;
        oam_addr_d = idx_q;
        idx_d      = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(DMA_LEN - 1)) state_d = DMA_IDLE;
      end
      default: state_d = DMA_IDLE;
    endcase
    // A restart discards this cycle's read; the write already pending still lands.
    if (start_c) begin
      src_d      = start_src;
      idx_d      = '0;
      dly_d      = '0;
      pend_d     = 1'b0;
      data_d     = 8'h00;
      oam_addr_d = '0;
      state_d    = (START_DELAY == 0) ? DMA_XFER : DMA_DELAY;
    end
  end

  // State and OAM write registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= DMA_IDLE;
      src_q      <= 8'h00;
      idx_q      <= '0;
      dly_q      <= '0;
      pend_q     <= 1'b0;
      data_q     <= 8'h00;
      oam_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      idx_q      <= idx_d;
      dly_q      <= dly_d;
      pend_q     <= pend_d;
      data_q     <= data_d;
      oam_addr_q <= oam_addr_d;
    end
  end

  assign xfer_c     = (state_q == DMA_XFER);
  assign dma_addr_c = {src_eff, idx_q};
  assign src        = src_q;
  assign oam_we     = pend_q;
  assign oam_addr   = oam_addr_q;
  assign oam_wdata  = data_q;
  assign dma_active = xfer_c | pend_q;

endmodule

// File: rtl/bus_arbiter.sv
// CPU bus arbiter: routes CPU accesses to the main bus or the high page and owns OAM DMA.
// Optional macro OAMDMA_ECHO_MIRROR_EN (see oam_dma_engine) mirrors DMA source pages E0-FF.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned DMA_LEN      = 160,
  parameter int unsigned START_DELAY  = 1,
  parameter logic [15:0] DMA_REG_ADDR = DEF_DMA_REG_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_rd_en,
  input  logic        cpu_wr_en,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        bus_rd_en,
  output logic        bus_wr_en,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        hp_rd_en,
  output logic        hp_wr_en,
  output logic [7:0]  hp_addr,
  output logic [7:0]  hp_wdata,
  input  logic [7:0]  hp_rdata,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        dma_active
);

  logic        is_dma_reg_c;
  logic        is_hp_c;
  logic        dma_start_c;
  logic        dma_xfer_c;
  logic [15:0] dma_addr_c;
  logic [7:0]  dma_src;

  assign is_dma_reg_c = (cpu_addr == DMA_REG_ADDR);
  assign is_hp_c      = (cpu_addr[15:8] == HP_PAGE);
  assign dma_start_c  = cpu_wr_en & is_dma_reg_c;

  oam_dma_engine #(
    .DMA_LEN     (DMA_LEN),
    .START_DELAY (START_DELAY)
  ) u_dma (
    .clk        (clk),
    .rst        (rst),
    .start_c    (dma_start_c),
    .start_src  (cpu_wdata),
    .bus_rdata  (bus_rdata),
    .xfer_c     (dma_xfer_c),
    .dma_addr_c (dma_addr_c),
    .src        (dma_src),
    .oam_we     (oam_we),
    .oam_addr   (oam_addr),
    .oam_wdata  (oam_wdata),
    .dma_active (dma_active)
  );

  // Address decode and port muxing; DMA owns the main bus during XFER.
  always_comb begin
    bus_rd_en = 1'b0;
    bus_wr_en = 1'b0;
    bus_addr  = 16'h0000;
    bus_wdata = 8'h00;
    hp_rd_en  = 1'b0;
    hp_wr_en  = 1'b0;
    hp_addr   = 8'h00;
    hp_wdata  = 8'h00;
    cpu_rdata = 8'hFF;
    if (dma_xfer_c) begin
      bus_rd_en = 1'b1;
      bus_addr  = dma_addr_c;
    end
    if (cpu_rd_en || cpu_wr_en) begin
      if (is_dma_reg_c) begin
        if (cpu_rd_en) cpu_rdata = dma_src;
      end else if (is_hp_c) begin
        hp_rd_en = cpu_rd_en;
        hp_wr_en = cpu_wr_en;
        hp_addr  = cpu_addr[7:0];
        if (cpu_wr_en) hp_wdata = cpu_wdata;
        if (cpu_rd_en) cpu_rdata = hp_rdata;
      end else if (!dma_xfer_c) begin
        bus_rd_en = cpu_rd_en;
        bus_wr_en = cpu_wr_en;
        bus_addr  = cpu_addr;
        if (cpu_wr_en) bus_wdata = cpu_wdata;
        if (cpu_rd_en) cpu_rdata = bus_rdata;
      end
    end
  end

endmodule
